// File: rtl/bin2bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int          BIN_W   = 14;
  localparam int          DIGITS  = 4;
  localparam int          MAX_DEC = 9999;
  localparam logic [15:0] SAT_BCD = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest decimal value representable in the given number of BCD digits.
  function automatic int max_dec(input int digits);
    int r;
    r = 1;
    for (int d = 0; d < digits; d++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_conv_dabble.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_dabble_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle,
// with valid/ready handshakes and saturation when the input exceeds the digit range.
module bin2bcd_conv
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = bin2bcd_pkg::BIN_W,
  parameter int DIGITS = bin2bcd_pkg::DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  localparam int              BW  = 4 * DIGITS;
  localparam int              CW  = $clog2(BIN_W + 1);
  localparam logic [BW-1:0]   SAT = {DIGITS{4'h9}};

  state_t            state_reg;
  state_t            state_next;
  logic [BIN_W-1:0]  bin_reg;
  logic [BW-1:0]     bcd_reg;
  logic [CW-1:0]     cnt_reg;
  logic              ovf_reg;
  logic [BW-1:0]     out_bcd_reg;
  logic              out_ovf_reg;

  logic [BW-1:0]     corrected;
  logic [BW-1:0]     shifted_bcd;
  logic              last_iter;
  logic              in_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_dabble_digit u_digit (
        .din  (bcd_reg[4*gi +: 4]),
        .dout (corrected[4*gi +: 4])
      );
    end
  endgenerate

  assign shifted_bcd = {corrected[BW-2:0], bin_reg[BIN_W-1]};
  assign last_iter   = (cnt_reg == CW'(1));
  assign in_ovf      = (int'(in_bin) > max_dec(DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = SHIFT;
      SHIFT:   if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // The result register is only written on the final iteration, so it keeps
  // the previous answer through IDLE and SHIFT and never shows partial values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg     <= '0;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      out_bcd_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            bin_reg <= in_bin;
            bcd_reg <= '0;
            cnt_reg <= CW'(BIN_W);
            ovf_reg <= in_ovf;
          end
        end
        SHIFT: begin
          bcd_reg <= shifted_bcd;
          bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
          cnt_reg <= cnt_reg - CW'(1);
          if (last_iter) begin
            out_bcd_reg <= ovf_reg ? SAT : shifted_bcd;
            out_ovf_reg <= ovf_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_bcd = out_bcd_reg;
  assign out_ovf = out_ovf_reg;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Scoreboard bench for bin2bcd_conv: directed corner cases plus random operands
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_conv;

  localparam int LAT = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_bin = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_bcd;
  logic        out_ovf;

  always #5 clk = ~clk;

  bin2bcd_conv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ovf   (out_ovf)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [16:0] exp_q[$];
  int          cyc = 0;
  int          accept_cyc = 0;
  int          handshakes = 0;
  int          bp_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits by division; saturate above 9999.
  function automatic logic [16:0] ref_model(input int v);
    logic [15:0] b;
    int          p;
    if (v > 9999) return {1'b1, 16'h9999};
    b = '0;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      b[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return {1'b0, b};
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endfunction

  // Backpressure driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every handshake against the scoreboard and checks protocol rules.
  initial begin
    logic        prev_valid, prev_ready, prev_hs, prev_ovf, digits_ok;
    logic [15:0] prev_bcd;
    logic [16:0] e;
    prev_valid = 0; prev_ready = 0; prev_hs = 0; prev_ovf = 0; prev_bcd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0; prev_hs = 0;
      end else begin
        digits_ok = 1'b1;
        for (int d = 0; d < 4; d++) if (out_bcd[4*d +: 4] > 4'd9) digits_ok = 1'b0;
        check("digit_range", 32'(digits_ok), 32'd1);
        check("ready_valid_exclusive", 32'(in_ready && out_valid), 32'd0);
        if (prev_hs) begin
          check("post_hs_valid", 32'(out_valid), 32'd0);
          check("post_hs_ready", 32'(in_ready), 32'd1);
        end
        if (out_valid && !prev_valid) check("latency", 32'(cyc - accept_cyc), 32'(LAT));
        if (out_valid && prev_valid && !prev_ready) begin
          check("hold_bcd", 32'(out_bcd), 32'(prev_bcd));
          check("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
        end
        if (out_valid && out_ready) begin
          handshakes++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got bcd 0x%0h ovf %0b, expected none", out_bcd, out_ovf);
          end else begin
            e = exp_q.pop_front();
            check("out_bcd", 32'(out_bcd), 32'(e[15:0]));
            check("out_ovf", 32'(out_ovf), 32'(e[16]));
          end
        end
        prev_hs    = out_valid && out_ready;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_bcd   = out_bcd;
        prev_ovf   = out_ovf;
      end
    end
  end

  task automatic send(input int v);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        timeout("send_wait_ready");
        return;
      end
    end
    in_valid   = 1'b1;
    in_bin     = 14'(v);
    accept_cyc = cyc + 1;
    exp_q.push_back(ref_model(v));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bin   = 14'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        timeout("drain");
        exp_q.delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int h0;
    int t;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_bcd", 32'(out_bcd), 32'h0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(0);
    drain();
    send(1234);
    send(9999);
    drain();
    send(10000);
    send(16383);
    drain();

    // Hold the result for six stalled cycles.
    bp_mode = 2;
    send(5050);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) timeout("wait_5050_valid");
    h0 = handshakes;
    repeat (6) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_bcd", 32'(out_bcd), 32'h5050);
    end
    bp_mode = 0;
    drain();
    repeat (2) @(negedge clk);
    check("single_handshake", 32'(handshakes - h0), 32'd1);
    check("ready_after_hs", 32'(in_ready), 32'd1);

    // Abort a conversion partway through.
    send(4321);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_bcd", 32'(out_bcd), 32'h0);
    check("abort_out_ovf", 32'(out_ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    check("abort_bcd_kept", 32'(out_bcd), 32'h0);
    send(87);
    drain();

    bp_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      send(int'($urandom_range(0, 16383)));
    end
    bp_mode = 0;
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
